// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
//   bcd_state_t : converter FSM states
//   bcd_digits  : minimum number of decimal digits needed for a w-bit unsigned value
//   BCD_ADJ_MIN / BCD_ADJ : double-dabble correction threshold and offset
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} bcd_state_t;

  localparam logic [3:0] BCD_ADJ_MIN = 4'd5;
  localparam logic [3:0] BCD_ADJ     = 4'd3;

  // ceil(w*log10(2)) in integer arithmetic. w*log10(2) is never an integer
  // for w >= 1, so this also equals the digit count of 2^w-1.
  function automatic int bcd_digits(int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is >= 5 so the
// following left shift carries correctly into the next decimal digit.
//   digit : current 4-bit BCD digit
//   adj   : corrected digit (combinational)
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= BCD_ADJ_MIN) ? digit + BCD_ADJ : digit;

endmodule

// File: rtl/bin_2_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Feeds the 7-segment decoders and flags leading-zero digits for blanking.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   start : conversion request, sampled only while idle
//   bin   : unsigned input, captured when start is accepted
//   busy  : high while converting
//   done  : one-cycle pulse when bcd/blank update
//   bcd   : digit k at bcd[4k+3:4k], digit 0 least significant
//   blank : leading-zero flags, blank[0] always 0
module bin_2_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam logic [DIGITS-1:0] RST_BLANK = ~(DIGITS'(1));

  if (BIN_WIDTH < 1) begin : g_bad_width
    $error("bin_2_bcd_seq: BIN_WIDTH must be >= 1");
  end
  if (DIGITS < bcd_digits(BIN_WIDTH)) begin : g_bad_digits
    $error("bin_2_bcd_seq: DIGITS too small for BIN_WIDTH");
  end

  bcd_state_t                 state;
  logic [CNT_W-1:0]           cnt;
  logic [BIN_WIDTH-1:0]       shift_reg;
  logic [DIGITS-1:0][3:0]     scratch;
  logic [DIGITS-1:0][3:0]     scratch_adj;
  logic [4*DIGITS-1:0]        adj_flat;
  logic [DIGITS-1:0]          blank_nxt;

  // Per-digit correction; digits are independent, no carry between them.
  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .digit (scratch[k]),
      .adj   (scratch_adj[k])
    );
  end

  assign adj_flat = scratch_adj;

  // A digit is blank when it and every digit above it are zero.
  // Digit 0 is never blanked so a zero value still shows "0".
  always_comb begin
    logic zeros;
    blank_nxt = '0;
    zeros     = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zeros        = zeros && (scratch[k] == 4'd0);
      blank_nxt[k] = zeros;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      blank     <= RST_BLANK;
      cnt       <= '0;
      shift_reg <= '0;
      scratch   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin;
            scratch   <= '0;
            cnt       <= CNT_W'(BIN_WIDTH - 1);
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // Correct first, then shift the next binary MSB into digit 0.
          scratch   <= {adj_flat[4*DIGITS-2:0], shift_reg[BIN_WIDTH-1]};
          shift_reg <= shift_reg << 1;
          if (cnt == '0) state <= FINISH;
          else           cnt   <= cnt - 1'b1;
        end
        FINISH: begin
          bcd   <= scratch;
          blank <= blank_nxt;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
